// File: rtl/rr_mux_8x1.sv
// rr_mux_8x1: 8-to-1 round-robin collecting multiplexer.
// Merges eight valid/ready channels onto a single registered output stream.
// The output stage holds one word together with the index of the channel
// that supplied it. Priority rotates to the channel after each granted one,
// so with all channels requesting, each channel is served once every 8 words.
module rr_mux_8x1 #(
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          in_valid,
    input  logic [8*DATA_W-1:0] in_data,
    output logic [7:0]          in_ready,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_data,
    output logic [2:0]          out_sel,
    input  logic                out_ready
);

    // Output stage occupancy: EMPTY has no word, FULL holds one word.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        ptr_q,   ptr_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic [2:0]        sel_q,   sel_d;

    logic              load_en;
    logic              grant_vld;
    logic [2:0]        grant_idx;
    logic [DATA_W-1:0] grant_data;
    logic              xfer;

    // Round-robin search: scan ptr, ptr+1, ... (3-bit wrap) for the first requester.
    always_comb begin
        logic [2:0] cand;
        // NOTE: every variable written here gets a default before any branch,
        // otherwise a path that skips an assignment would infer a latch.
        grant_vld = 1'b0;
        grant_idx = ptr_q;
        cand      = ptr_q;
        for (int k = 0; k < 8; k++) begin
            cand = ptr_q + 3'(k);
            if (!grant_vld && in_valid[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // Word presented by the granted channel.
    assign grant_data = in_data[32'(grant_idx) * DATA_W +: DATA_W];

    // Handshake: accept into the output stage only when it is empty or draining.
    always_comb begin
        load_en  = (state_q == ST_EMPTY) || out_ready;
        // A reset cycle never accepts a word, so upstream must not see ready.
        xfer     = !rst && load_en && grant_vld;
        in_ready = 8'b0;
        if (xfer) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    // Next-state and next-output computation for the output stage.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        sel_d   = sel_q;
        if (xfer) begin
            // Load the granted word; priority moves to the following channel.
            state_d = ST_FULL;
            data_d  = grant_data;
            sel_d   = grant_idx;
            ptr_d   = grant_idx + 3'd1;
        end else if (state_q == ST_FULL && out_ready) begin
            // Downstream took the word and nothing replaces it; data/sel keep
            // their last value so the bus does not toggle needlessly.
            state_d = ST_EMPTY;
        end
    end

    // State register with synchronous reset; reset discards any held word.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q <= ST_EMPTY;
            ptr_q   <= 3'd0;
            data_q  <= '0;
            sel_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign out_data  = data_q;
    assign out_sel   = sel_q;

endmodule

// File: tb/tb_rr_mux_8x1.sv
// tb_rr_mux_8x1: scoreboard bench for the 8-to-1 round-robin mux.
// A driver applies directed and random stimulus and, from a behavioural
// model of the arbitration rules, predicts in_ready and the output register,
// pushing every expected output word into a queue. A separate monitor pops
// and compares whenever downstream accepts a word.
module tb_rr_mux_8x1;

    typedef struct packed {
        logic [2:0] sel;
        logic [7:0] data;
    } word_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_valid;
    logic [63:0] in_data;
    logic [7:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [2:0]  out_sel;
    logic        out_ready;

    int checks = 0;
    int errors = 0;

    word_t exp_q[$];

    // Behavioural model state.
    bit       m_known = 0;
    int       m_ptr   = 0;
    bit       m_full  = 0;
    int       m_sel   = 0;
    int       m_data  = 0;

    rr_mux_8x1 #(.DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive at posedge+1, check and advance the model at negedge.
    task automatic step(input logic r, input logic [7:0] v, input logic [63:0] d, input logic ordy);
        int         g;
        bit         found;
        logic [7:0] exp_rdy;
        rst       = r;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        @(negedge clk);
        if (m_known) begin
            check("out_valid", out_valid, m_full);
            check("out_sel", out_sel, m_sel);
            check("out_data", out_data, m_data);
        end
        found = 0;
        g     = 0;
        for (int k = 0; k < 8; k++) begin
            if (!found && v[(m_ptr + k) % 8]) begin
                found = 1;
                g     = (m_ptr + k) % 8;
            end
        end
        exp_rdy = 8'b0;
        if (!r && m_known && (!m_full || ordy) && found) exp_rdy = 8'(1 << g);
        if (r || m_known) check("in_ready", in_ready, exp_rdy);
        if (r) begin
            m_known = 1;
            m_ptr   = 0;
            m_full  = 0;
            m_sel   = 0;
            m_data  = 0;
            exp_q.delete();
        end else if (exp_rdy != 8'b0) begin
            m_sel  = g;
            m_data = int'(d[g*8 +: 8]);
            m_full = 1;
            m_ptr  = (g + 1) % 8;
            exp_q.push_back(word_t'{sel: 3'(g), data: d[g*8 +: 8]});
        end else if (m_full && ordy) begin
            m_full = 0;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] ramp(input int base);
        logic [63:0] d;
        for (int i = 0; i < 8; i++) d[i*8 +: 8] = 8'(base + i);
        return d;
    endfunction

    // Monitor: each word accepted downstream must match the next expected word.
    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got sel %0d data %0h expected none at %0t",
                         out_sel, out_data, $time);
            end else begin
                word_t e;
                e = exp_q.pop_front();
                check("word_sel", out_sel, e.sel);
                check("word_data", out_data, e.data);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] d;
        logic [7:0]  v;
        logic        r, o;
        rst = 1'b1; in_valid = 8'h00; in_data = '0; out_ready = 1'b0;
        #1;

        // Reset with every channel requesting: nothing accepted.
        step(1'b1, 8'hFF, ramp(8'h10), 1'b0);
        step(1'b1, 8'hFF, ramp(8'h10), 1'b0);

        // Single channel 5.
        d = '0; d[5*8 +: 8] = 8'hA5;
        step(1'b0, 8'b0010_0000, d, 1'b1);
        step(1'b0, 8'h00, '0, 1'b1);
        check("single_sel", out_sel, 3'd5);
        check("single_data", out_data, 8'hA5);

        // Full rotation from ptr=0 after reset: 0..7,0.
        step(1'b1, 8'h00, '0, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b0, 8'hFF, ramp(8'h10), 1'b1);

        // Backpressure with sel=2/data=12 held, then grant resumes at ch3.
        step(1'b1, 8'h00, '0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 8'hFF, ramp(8'h10), 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 8'hFF, ramp(8'h10), 1'b0);
        check("stall_sel", out_sel, 3'd2);
        check("stall_data", out_data, 8'h12);
        step(1'b0, 8'hFF, ramp(8'h10), 1'b1);
        step(1'b0, 8'h00, '0, 1'b1);
        check("resume_sel", out_sel, 3'd3);

        // Wrap and skip: ptr=7 with ch0/ch2 requesting -> 0, 2, 0.
        d = '0; d[6*8 +: 8] = 8'h66;
        step(1'b0, 8'b0100_0000, d, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 8'b0000_0101, ramp(8'h40), 1'b1);

        // Drain, then a reset during a stall discards the held word.
        step(1'b0, 8'h00, '0, 1'b1);
        step(1'b0, 8'h00, '0, 1'b1);
        step(1'b0, 8'h08, ramp(8'h70), 1'b1);
        step(1'b0, 8'h00, '0, 1'b0);
        step(1'b1, 8'h00, '0, 1'b0);
        step(1'b0, 8'h00, '0, 1'b0);

        // Random traffic; reset is rare and always with downstream not ready.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 8; i++) d[i*8 +: 8] = 8'($urandom);
            v = 8'($urandom) & 8'($urandom | ($urandom_range(0, 1) ? 32'hFF : 32'h0));
            o = ($urandom_range(0, 9) < 7);
            r = ($urandom_range(0, 199) == 0);
            if (r) o = 1'b0;
            step(r, v, d, o);
        end

        // Drain the last word; every expected word must have been seen.
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, '0, 1'b1);
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
